// File: rtl/alarm_buzzer_cntr.sv
// Alarm stage behind the hour/minute watch core: editable BCD alarm time,
// edge-triggered ring with stop/snooze/timeout, square-wave buzzer and display mux.
module alarm_buzzer_cntr #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned TONE_HZ  = 1000,
  parameter int unsigned RING_S   = 60,
  parameter int unsigned SNOOZE_S = 300
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] time_value,
  input  logic        set_mode,
  input  logic        sec_tick,
  input  logic        alarm_set_btn,
  input  logic        inc_hour,
  input  logic        inc_min,
  input  logic        stop_btn,
  input  logic        snooze_btn,
  output logic [15:0] alarm_value,
  output logic [15:0] disp_value,
  output logic        armed,
  output logic        editing,
  output logic        ringing,
  output logic        buzz
);

  localparam int unsigned HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int unsigned TW   = $clog2(HALF + 1);
  localparam int unsigned RW   = $clog2(RING_S + 1);
  localparam int unsigned SW   = $clog2(SNOOZE_S + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT,
    S_ARMED,
    S_RINGING,
    S_SNOOZE
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     alarm_q, alarm_d;
  logic            match_q, match_d;
  logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
  logic [SW-1:0]   snz_cnt_q, snz_cnt_d;
  logic [TW-1:0]   tone_cnt_q, tone_cnt_d;
  logic            tone_q, tone_d;
  logic            armed_q, armed_d;
  logic            editing_q, editing_d;
  logic            ringing_q, ringing_d;
  logic            trig;
  logic [7:0]      hr, mn;

  always_comb begin
    match_d   = (time_value == alarm_q) && !set_mode;
    trig      = match_d && !match_q;
    state_d   = state_q;
    alarm_d   = alarm_q;
    hr        = alarm_q[15:8];
    mn        = alarm_q[7:0];

    case (state_q)
      S_IDLE: begin
        if (alarm_set_btn) state_d = S_EDIT;
      end
      S_EDIT: begin
        if (!set_mode) begin
          if (inc_hour) begin
            if (alarm_q[15:8] == 8'h23)      hr = 8'h00;
            else if (alarm_q[11:8] == 4'd9) hr = {alarm_q[15:12] + 4'd1, 4'd0};
            else                             hr = {alarm_q[15:12], alarm_q[11:8] + 4'd1};
          end
          if (inc_min) begin
            if (alarm_q[3:0] == 4'd9)
              mn = {(alarm_q[7:4] == 4'd5) ? 4'd0 : alarm_q[7:4] + 4'd1, 4'd0};
            else
              mn = {alarm_q[7:4], alarm_q[3:0] + 4'd1};
          end
          alarm_d = {hr, mn};
        end
        if (stop_btn)           state_d = S_IDLE;
        else if (alarm_set_btn) state_d = S_ARMED;
      end
      S_ARMED: begin
        // Buttons take priority over a coincident trigger.
        if (stop_btn)           state_d = S_IDLE;
        else if (alarm_set_btn) state_d = S_EDIT;
        else if (trig)          state_d = S_RINGING;
      end
      S_RINGING: begin
        if (stop_btn)                                     state_d = S_ARMED;
        else if (snooze_btn)                              state_d = S_SNOOZE;
        else if (sec_tick && ring_cnt_q == RW'(RING_S - 1)) state_d = S_ARMED;
      end
      S_SNOOZE: begin
        if (stop_btn)                                       state_d = S_ARMED;
        else if (sec_tick && snz_cnt_q == SW'(SNOOZE_S - 1)) state_d = S_RINGING;
      end
      default: state_d = S_IDLE;
    endcase

    // Counters run only while staying in their state, so entry always starts at 0.
    ring_cnt_d = '0;
    if (state_q == S_RINGING && state_d == S_RINGING)
      ring_cnt_d = sec_tick ? ring_cnt_q + RW'(1) : ring_cnt_q;

    snz_cnt_d = '0;
    if (state_q == S_SNOOZE && state_d == S_SNOOZE)
      snz_cnt_d = sec_tick ? snz_cnt_q + SW'(1) : snz_cnt_q;

    tone_cnt_d = '0;
    tone_d     = 1'b0;
    if (state_q == S_RINGING && state_d == S_RINGING) begin
      if (tone_cnt_q == TW'(HALF - 1)) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + TW'(1);
        tone_d     = tone_q;
      end
    end

    armed_d   = (state_d == S_ARMED) || (state_d == S_RINGING) || (state_d == S_SNOOZE);
    editing_d = (state_d == S_EDIT);
    ringing_d = (state_d == S_RINGING);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      alarm_q    <= '0;
      match_q    <= 1'b0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      armed_q    <= 1'b0;
      editing_q  <= 1'b0;
      ringing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alarm_q    <= alarm_d;
      match_q    <= match_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      armed_q    <= armed_d;
      editing_q  <= editing_d;
      ringing_q  <= ringing_d;
    end
  end

  assign alarm_value = alarm_q;
  assign disp_value  = editing_q ? alarm_q : time_value;
  assign armed       = armed_q;
  assign editing     = editing_q;
  assign ringing     = ringing_q;
  assign buzz        = tone_q & ringing_q;

endmodule

// File: tb/tb_alarm_buzzer_cntr.sv
// Bench for alarm_buzzer_cntr: vector table of per-cycle stimulus and expected
// outputs run through a scoreboard queue, then an asynchronous mid-ring reset.
module tb_alarm_buzzer_cntr;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] time_value;
  logic        set_mode;
  logic        sec_tick;
  logic        alarm_set_btn;
  logic        inc_hour;
  logic        inc_min;
  logic        stop_btn;
  logic        snooze_btn;
  logic [15:0] alarm_value;
  logic [15:0] disp_value;
  logic        armed;
  logic        editing;
  logic        ringing;
  logic        buzz;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // btn = {alarm_set, inc_hour, inc_min, stop, snooze, sec_tick}
  // ef  = {armed, editing, ringing, buzz}
  typedef struct {
    string       nm;
    logic [5:0]  btn;
    logic [15:0] tm;
    logic        sm;
    logic [15:0] ea;
    logic [3:0]  ef;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  alarm_buzzer_cntr #(
    .CLK_HZ  (1000),
    .TONE_HZ (100),
    .RING_S  (3),
    .SNOOZE_S(2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .time_value   (time_value),
    .set_mode     (set_mode),
    .sec_tick     (sec_tick),
    .alarm_set_btn(alarm_set_btn),
    .inc_hour     (inc_hour),
    .inc_min      (inc_min),
    .stop_btn     (stop_btn),
    .snooze_btn   (snooze_btn),
    .alarm_value  (alarm_value),
    .disp_value   (disp_value),
    .armed        (armed),
    .editing      (editing),
    .ringing      (ringing),
    .buzz         (buzz)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void add(input string nm, input logic [5:0] btn, input logic [15:0] tm,
                              input logic sm, input logic [15:0] ea, input logic [3:0] ef);
    vec_t v;
    v.nm = nm; v.btn = btn; v.tm = tm; v.sm = sm; v.ea = ea; v.ef = ef;
    tbl.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    {alarm_set_btn, inc_hour, inc_min, stop_btn, snooze_btn, sec_tick} = v.btn;
    time_value = v.tm;
    set_mode   = v.sm;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.nm, ".alarm"},   alarm_value, e.ea);
    chk({e.nm, ".disp"},    disp_value,  e.ef[2] ? e.ea : e.tm);
    chk({e.nm, ".armed"},   16'(armed),   16'(e.ef[3]));
    chk({e.nm, ".editing"}, 16'(editing), 16'(e.ef[2]));
    chk({e.nm, ".ringing"}, 16'(ringing), 16'(e.ef[1]));
    chk({e.nm, ".buzz"},    16'(buzz),    16'(e.ef[0]));
  endtask

  initial begin
    // ---- vector table ----
    add("idle_tick",  6'b000001, 16'h1200, 1'b0, 16'h0000, 4'b0000);
    add("idle_inc",   6'b011000, 16'h1200, 1'b0, 16'h0000, 4'b0000);
    add("idle_stop",  6'b000100, 16'h1200, 1'b0, 16'h0000, 4'b0000);
    add("enter_edit", 6'b100000, 16'h1200, 1'b0, 16'h0000, 4'b0100);
    for (int h = 1; h <= 23; h++)
      add("inc_hour", 6'b010000, 16'h1200, 1'b0, {4'(h / 10), 4'(h % 10), 8'h00}, 4'b0100);
    for (int m = 1; m <= 59; m++)
      add("inc_min", 6'b001000, 16'h1200, 1'b0, {8'h23, 4'(m / 10), 4'(m % 10)}, 4'b0100);
    add("wrap_both",    6'b011000, 16'h1200, 1'b0, 16'h0000, 4'b0100);
    add("setmode_gate", 6'b011000, 16'h1200, 1'b1, 16'h0000, 4'b0100);
    for (int h = 1; h <= 7; h++)
      add("set_hour", 6'b010000, 16'h1200, 1'b0, {8'(h), 8'h00}, 4'b0100);
    for (int m = 1; m <= 30; m++)
      add("set_min", 6'b001000, 16'h1200, 1'b0, {8'h07, 4'(m / 10), 4'(m % 10)}, 4'b0100);
    add("edit_stop",     6'b000100, 16'h1200, 1'b0, 16'h0730, 4'b0000);
    add("idle_ignore",   6'b010000, 16'h1200, 1'b0, 16'h0730, 4'b0000);
    add("re_edit",       6'b100000, 16'h1200, 1'b0, 16'h0730, 4'b0100);
    add("arm",           6'b100000, 16'h1200, 1'b0, 16'h0730, 4'b1000);
    add("armed_to_edit", 6'b100000, 16'h1200, 1'b0, 16'h0730, 4'b0100);
    add("rearm",         6'b100000, 16'h1200, 1'b0, 16'h0730, 4'b1000);
    add("t0731",         6'b000000, 16'h0731, 1'b0, 16'h0730, 4'b1000);
    add("btn_wins",      6'b100000, 16'h0730, 1'b0, 16'h0730, 4'b0100);
    add("arm_on_match",  6'b100000, 16'h0730, 1'b0, 16'h0730, 4'b1000);
    add("hold_match",    6'b000000, 16'h0730, 1'b0, 16'h0730, 4'b1000);
    add("t0729",         6'b000000, 16'h0729, 1'b0, 16'h0730, 4'b1000);
    add("ring",          6'b000000, 16'h0730, 1'b0, 16'h0730, 4'b1010);
    for (int k = 1; k <= 16; k++)
      add("tone", 6'b000000, 16'h0730, 1'b0, 16'h0730, {3'b101, ((k / 5) % 2) == 1});
    add("stop",          6'b000100, 16'h0730, 1'b0, 16'h0730, 4'b1000);
    for (int k = 0; k < 3; k++)
      add("no_rering", 6'b000000, 16'h0730, 1'b0, 16'h0730, 4'b1000);
    // timeout after RING_S ticks
    add("to_0731",  6'b000000, 16'h0731, 1'b0, 16'h0730, 4'b1000);
    add("ring2",    6'b000000, 16'h0730, 1'b0, 16'h0730, 4'b1010);
    add("rtick1",   6'b000001, 16'h0730, 1'b0, 16'h0730, 4'b1010);
    add("rtick2",   6'b000001, 16'h0730, 1'b0, 16'h0730, 4'b1010);
    add("timeout",  6'b000001, 16'h0730, 1'b0, 16'h0730, 4'b1000);
    add("post_to",  6'b000000, 16'h0730, 1'b0, 16'h0730, 4'b1000);
    // snooze
    add("sn_0731",   6'b000000, 16'h0731, 1'b0, 16'h0730, 4'b1000);
    add("ring3",     6'b000000, 16'h0730, 1'b0, 16'h0730, 4'b1010);
    add("snooze",    6'b000010, 16'h0730, 1'b0, 16'h0730, 4'b1000);
    add("snz_0731",  6'b000000, 16'h0731, 1'b0, 16'h0730, 4'b1000);
    add("snz_trig",  6'b000000, 16'h0730, 1'b0, 16'h0730, 4'b1000);
    add("snz_tick1", 6'b000001, 16'h0730, 1'b0, 16'h0730, 4'b1000);
    add("snz_tick2", 6'b000001, 16'h0730, 1'b0, 16'h0730, 4'b1010);
    add("stop_wins", 6'b000110, 16'h0730, 1'b0, 16'h0730, 4'b1000);
    for (int k = 0; k < 3; k++)
      add("no_snooze", 6'b000001, 16'h0730, 1'b0, 16'h0730, 4'b1000);
    // set_mode gating, then ring for the reset test
    add("sm_0731",    6'b000000, 16'h0731, 1'b0, 16'h0730, 4'b1000);
    add("sm_match",   6'b000000, 16'h0730, 1'b1, 16'h0730, 4'b1000);
    add("sm_hold",    6'b000000, 16'h0730, 1'b1, 16'h0730, 4'b1000);
    add("sm_release", 6'b000000, 16'h0730, 1'b0, 16'h0730, 4'b1010);
    for (int k = 1; k <= 6; k++)
      add("tone_r", 6'b000000, 16'h0730, 1'b0, 16'h0730, {3'b101, k >= 5});

    // ---- reset ----
    reset_n = 1'b0;
    {alarm_set_btn, inc_hour, inc_min, stop_btn, snooze_btn, sec_tick} = '0;
    time_value = 16'h1200;
    set_mode   = 1'b0;
    #3;
    chk("rst.alarm",   alarm_value, 16'h0000);
    chk("rst.disp",    disp_value,  16'h1200);
    chk("rst.outs",    {12'h000, armed, editing, ringing, buzz}, 16'h0000);
    #9 reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i]);

    // ---- asynchronous reset mid-ring, between clock edges ----
    chk("pre_rst.buzz",    16'(buzz),    16'h0001);
    chk("pre_rst.ringing", 16'(ringing), 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.buzz",    16'(buzz),    16'h0000);
    chk("arst.ringing", 16'(ringing), 16'h0000);
    chk("arst.armed",   16'(armed),   16'h0000);
    chk("arst.editing", 16'(editing), 16'h0000);
    chk("arst.alarm",   alarm_value,  16'h0000);
    #3 reset_n = 1'b1;
    chk("sb_empty", 16'(sb.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_buzzer_cntr.md
Name: alarm_buzzer_cntr

Overview:
Alarm stage placed directly downstream of the hour/minute watch core. It consumes the watch's BCD time word {hour10, hour1, min10, min1} and its set_mode flag, and holds a user-editable BCD alarm time. On a match it drives a square-wave buzzer, with stop, snooze and auto-timeout. It also supplies the 16-bit word shown on the 4-digit FND controller: the alarm time while editing, the live time otherwise.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz.
TONE_HZ, 1000, buzzer square-wave frequency; HALF = CLK_HZ/(2*TONE_HZ) clk cycles per half period.
RING_S, 60, sec_tick count after which an unattended ring stops by itself.
SNOOZE_S, 300, sec_tick count spent in snooze before ringing again.

Ports:
clk  in  1  system clock, all logic rising-edge.
reset_n  in  1  asynchronous active-low reset.
time_value  in  16  current time, BCD {h10,h1,m10,m1}.
set_mode  in  1  watch core is in its own time-set mode.
sec_tick  in  1  one-clk pulse per second.
alarm_set_btn  in  1  one-clk debounced pulse: enter or leave edit.
inc_hour  in  1  one-clk pulse: alarm hour +1.
inc_min  in  1  one-clk pulse: alarm minute +1.
stop_btn  in  1  one-clk pulse: stop ring or disarm.
snooze_btn  in  1  one-clk pulse: snooze while ringing.
alarm_value  out  16  alarm time, BCD {h10,h1,m10,m1}.
disp_value  out  16  equals alarm_value in EDIT, time_value otherwise (combinational mux).
armed  out  1  high in ARMED, RINGING or SNOOZE.
editing  out  1  high in EDIT.
ringing  out  1  high in RINGING.
buzz  out  1  buzzer drive.

Behaviour:
- One clock, clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, alarm_value=16'h0000, armed=0, editing=0, ringing=0, buzz=0, all counters 0, match_d=0.
- match = (time_value == alarm_value) & ~set_mode. match_d is match registered every cycle in every state.
- trig = match & ~match_d, a rising-edge trigger. Entering ARMED while match is already true does not ring.
- State outputs are registered, so each updates one clk after its transition cycle.
- IDLE:
  - alarm_set_btn -> EDIT.
  - All other inputs are ignored.
- EDIT:
  - inc_hour: h10:h1 counts 00..23, 23 -> 00.
  - inc_min: m10:m1 counts 00..59, 59 -> 00, with no carry into the hour.
  - Both increments are ignored while set_mode=1.
  - inc_hour and inc_min in the same cycle both apply.
  - alarm_set_btn -> ARMED.
  - stop_btn -> IDLE, and alarm_value is kept.
- ARMED:
  - trig -> RINGING.
  - alarm_set_btn -> EDIT.
  - stop_btn -> IDLE.
  - When trig and a button pulse arrive in the same cycle, the button wins.
- RINGING:
  - On entry ring_cnt=0; ring_cnt increments on each sec_tick.
  - Exits, highest priority first:
    1. stop_btn -> ARMED.
    2. snooze_btn -> SNOOZE.
    3. ring_cnt==RING_S-1 together with sec_tick -> ARMED.
  - alarm_set_btn is ignored.
  - Returning to ARMED does not re-ring within the same minute, because of the edge trigger.
- SNOOZE:
  - On entry snz_cnt=0; snz_cnt increments on each sec_tick.
  - stop_btn -> ARMED.
  - snz_cnt==SNOOZE_S-1 together with sec_tick -> RINGING, with ring_cnt cleared.
  - trig is ignored.
- Tone generation:
  - tone_cnt counts 0..HALF-1 in RINGING only; the tone toggles at HALF-1.
  - tone_cnt and tone are held at 0 outside RINGING.
  - buzz = tone & ringing, so the first 1 appears HALF cycles after ringing rises.
  - buzz is 0 within one clk of leaving RINGING.
- Mid-operation reset: an asynchronous drop of reset_n clears buzz and every other output immediately, with no clk edge required.
- alarm_value increments are BCD-correct: the ones digit wraps 9 -> 0 with a carry into the tens digit. Non-BCD values never occur.

Test Plan:
- Reset. Apply 1 sec_tick, inc_min and inc_hour -> all outputs 0, alarm_value=16'h0000, state IDLE.
- Edit wrap: alarm_set_btn, then 23 inc_hour, 59 inc_min -> alarm_value=16'h2359 and disp_value=16'h2359. One more inc_hour and one more inc_min -> alarm_value=16'h0000.
- Ring and stop, with CLK_HZ=1000 and TONE_HZ=100 (HALF=5):
  - Alarm 07:30, armed; time_value steps 0729 -> 0730 -> ringing=1.
  - buzz toggles every 5 clk, first high 5 clk after ringing rises.
  - stop_btn -> ringing=0, buzz=0, armed=1.
  - With time still 0730, no re-ring.
- Timeout: with RING_S=3, no buttons -> after the 3rd sec_tick the block returns to ARMED with buzz=0.
- Snooze, with SNOOZE_S=2:
  - snooze_btn while ringing -> ringing=0, armed=1.
  - After 2 sec_ticks -> ringing=1.
  - stop_btn and snooze_btn in the same cycle -> ARMED, since stop wins.
- set_mode gating and reset:
  - time_value equal to alarm with set_mode=1 -> no ring.
  - Deassert reset_n mid-ring -> buzz and ringing 0 asynchronously, alarm_value=16'h0000.
